// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter with a one-entry holding register.
// A byte written while the line is idle goes straight to the shifter. A byte
// written while a frame is in flight waits in the holding register and is
// launched at stop end, so back-to-back bytes leave with no idle gap.
`timescale 1ns/1ps
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 2604
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_write,
  input  logic [DATA_BITS-1:0] tx_bus,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_full,
  output logic                 tx_done_tick,
  output logic                 overrun
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 ovr_q, ovr_d;

  logic bit_wrap;
  logic stop_end;
  logic drain;
  logic accept;
  logic to_hold;

  // Next-state logic: frame sequencing, bit timing, holding register and
  // registered line/flag values derived from the next state.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    full_d    = full_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;

    bit_wrap = (clk_cnt_q == CNT_LAST);
    stop_end = (state_q == STOP) && bit_wrap && (bit_cnt_q == STOP_LAST);
    // The holding register empties when its byte is launched this cycle.
    drain    = full_q && (stop_end || (state_q == IDLE));
    accept   = tx_write && (!full_q || drain);
    // Only an idle line with an empty holding register bypasses the holder.
    to_hold  = accept && !((state_q == IDLE) && !full_q);

    // Cycle counter runs in every active state and wraps once per bit.
    if (state_q == IDLE) begin
      clk_cnt_d = '0;
    end else if (bit_wrap) begin
      clk_cnt_d = '0;
    end else begin
      clk_cnt_d = clk_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        if (full_q) begin
          state_d = START;
          shift_d = hold_q;
        end else if (tx_write) begin
          state_d = START;
          shift_d = tx_bus;
        end
      end
      START: begin
        if (bit_wrap) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == DATA_LAST) begin
            state_d   = STOP;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_wrap) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            if (full_q) begin
              state_d = START;
              shift_d = hold_q;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        // Raise the pulse one cycle early so the register shows it in the
        // final stop cycle.
        if ((bit_cnt_q == STOP_LAST) && (clk_cnt_q == CNT_PRE)) begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (drain) begin
      full_d = 1'b0;
    end
    if (to_hold) begin
      hold_d = tx_bus;
      full_d = 1'b1;
    end
    ovr_d = tx_write && !accept;

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame and drops the queued byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      hold_q    <= '0;
      full_q    <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      hold_q    <= hold_d;
      full_q    <= full_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_full      = full_q;
  assign tx_done_tick = done_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx at 16 clocks per bit, 8N1.
`timescale 1ns/1ps
module tb_uart_tx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       tx_write;
  logic [7:0] tx_bus;
  logic       tx;
  logic       tx_busy;
  logic       tx_full;
  logic       tx_done_tick;
  logic       overrun;

  int tests;
  int fails;
  int cyc;
  int done_cnt;
  int ovr_cnt;
  int last_done;
  int prev_done;
  int base_done;
  int base_ovr;

  uart_tx #(
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_write    (tx_write),
    .tx_bus      (tx_bus),
    .tx          (tx),
    .tx_busy     (tx_busy),
    .tx_full     (tx_full),
    .tx_done_tick(tx_done_tick),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor on the inactive edge.
  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) begin
      done_cnt  <= done_cnt + 1;
      prev_done <= last_done;
      last_done <= cyc;
    end
    if (overrun === 1'b1) ovr_cnt <= ovr_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Line level expected in bit slot k of a frame carrying b.
  function automatic logic expbit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s tx i%0d", tag, i), 32'(tx), 32'(1'b1));
      chk($sformatf("%s busy i%0d", tag, i), 32'(tx_busy), 32'(1'b0));
      chk($sformatf("%s full i%0d", tag, i), 32'(tx_full), 32'(1'b0));
      chk($sformatf("%s done i%0d", tag, i), 32'(tx_done_tick), 32'(1'b0));
      chk($sformatf("%s ovr i%0d", tag, i), 32'(overrun), 32'(1'b0));
    end
  endtask

  // Called at the negedge of the cycle before the frame's first cycle; checks
  // every frame cycle and optionally writes in frame cycles wa / wb.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic start_full,
                             input int wa, input logic [7:0] ba,
                             input int wb, input logic [7:0] bb);
    logic full_m;
    logic ovr_m;
    logic w;
    logic drain;
    logic acc;
    full_m = start_full;
    ovr_m  = 1'b0;
    for (int c = 1; c <= 10 * CPB; c++) begin
      @(negedge clk);
      chk($sformatf("%s tx c%0d", tag, c), 32'(tx), 32'(expbit(b, (c - 1) / CPB)));
      chk($sformatf("%s busy c%0d", tag, c), 32'(tx_busy), 32'(1'b1));
      chk($sformatf("%s full c%0d", tag, c), 32'(tx_full), 32'(full_m));
      chk($sformatf("%s ovr c%0d", tag, c), 32'(overrun), 32'(ovr_m));
      chk($sformatf("%s done c%0d", tag, c), 32'(tx_done_tick), 32'(c == 10 * CPB));
      w        = (c == wa) || (c == wb);
      tx_write = w;
      tx_bus   = w ? ((c == wa) ? ba : bb) : (8'(c) ^ 8'h5A);
      drain    = (c == 10 * CPB) && full_m;
      acc      = w && (!full_m || drain);
      ovr_m    = w && !acc;
      full_m   = acc ? 1'b1 : (drain ? 1'b0 : full_m);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; done_cnt = 0; ovr_cnt = 0;
    last_done = 0; prev_done = 0;
    rst = 1'b1; tx_write = 1'b0; tx_bus = 8'h00;

    // Reset state, then 50 idle cycles.
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx), 32'(1'b1));
    chk("rst busy", 32'(tx_busy), 32'(1'b0));
    chk("rst full", 32'(tx_full), 32'(1'b0));
    chk("rst done", 32'(tx_done_tick), 32'(1'b0));
    chk("rst ovr", 32'(overrun), 32'(1'b0));
    rst = 1'b0;
    idle_check("idle50", 50);
    chk("idle50 done count", 32'(done_cnt), 32'(0));
    chk("idle50 ovr count", 32'(ovr_cnt), 32'(0));

    // Single byte 0xA5.
    tx_write = 1'b1; tx_bus = 8'hA5;
    check_frame("a5", 8'hA5, 1'b0, 0, 8'h00, 0, 8'h00);
    idle_check("a5 after", 5);
    chk("a5 done count", 32'(done_cnt), 32'(1));

    // 0x55, then 0x0F queued in frame cycle 20; no gap between frames.
    tx_write = 1'b1; tx_bus = 8'h55;
    check_frame("55", 8'h55, 1'b0, 20, 8'h0F, 0, 8'h00);
    check_frame("0f", 8'h0F, 1'b0, 0, 8'h00, 0, 8'h00);
    idle_check("0f after", 3);
    chk("55/0f done count", 32'(done_cnt), 32'(3));
    chk("55/0f done spacing", 32'(last_done - prev_done), 32'(10 * CPB));

    // 0x01, 0x02, 0x03 on consecutive cycles; 0x03 dropped.
    base_ovr = ovr_cnt;
    tx_write = 1'b1; tx_bus = 8'h01;
    check_frame("01", 8'h01, 1'b0, 1, 8'h02, 2, 8'h03);
    check_frame("02", 8'h02, 1'b0, 0, 8'h00, 0, 8'h00);
    idle_check("02 after", 20);
    chk("overrun count", 32'(ovr_cnt - base_ovr), 32'(1));
    chk("01/02 done count", 32'(done_cnt), 32'(5));

    // 0xFF with 0x77 queued, reset in frame cycle 40 (with a write that must be ignored).
    base_done = done_cnt;
    tx_write = 1'b1; tx_bus = 8'hFF;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk($sformatf("ff tx c%0d", c), 32'(tx), 32'(expbit(8'hFF, (c - 1) / CPB)));
      chk($sformatf("ff busy c%0d", c), 32'(tx_busy), 32'(1'b1));
      tx_write = (c == 5);
      tx_bus   = (c == 5) ? 8'h77 : 8'h00;
    end
    chk("ff queued full", 32'(tx_full), 32'(1'b1));
    rst = 1'b1; tx_write = 1'b1; tx_bus = 8'h99;
    @(negedge clk);
    rst = 1'b0; tx_write = 1'b0;
    chk("abort tx", 32'(tx), 32'(1'b1));
    chk("abort busy", 32'(tx_busy), 32'(1'b0));
    chk("abort full", 32'(tx_full), 32'(1'b0));
    chk("abort done", 32'(tx_done_tick), 32'(1'b0));
    chk("abort ovr", 32'(overrun), 32'(1'b0));
    idle_check("abort idle", 200);
    chk("abort done count", 32'(done_cnt - base_done), 32'(0));
    tx_write = 1'b1; tx_bus = 8'h3C;
    check_frame("3c", 8'h3C, 1'b0, 0, 8'h00, 0, 8'h00);
    idle_check("3c after", 3);

    // Queue 0x22, then write 0x33 in the exact stop-end cycle.
    base_ovr  = ovr_cnt;
    base_done = done_cnt;
    tx_write = 1'b1; tx_bus = 8'h11;
    check_frame("11", 8'h11, 1'b0, 5, 8'h22, 10 * CPB, 8'h33);
    check_frame("22", 8'h22, 1'b1, 0, 8'h00, 0, 8'h00);
    check_frame("33", 8'h33, 1'b0, 0, 8'h00, 0, 8'h00);
    idle_check("33 after", 5);
    chk("stop-end ovr count", 32'(ovr_cnt - base_ovr), 32'(0));
    chk("stop-end done count", 32'(done_cnt - base_done), 32'(3));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
